cpu_mc: RTL
===========

# cpu_mc

Parameterised multi-cycle successor to the 16-bit CPU core: same ISA and the same four-phase memory handshake (readM/writeM, inputReady/ackOutput), built as an explicit clocked FSM rather than blocking waits. Adds a configurable reset vector, a bus-timeout fault, retired-instruction counting, an output port (WWD) and a halt instruction (HLT). Sits between the testbench memory model and the system top, replacing the current core.

## Interface

**Parameters**
- RESET_PC, 16'h0000, PC value loaded at reset.
- TIMEOUT, 255, maximum cycles any handshake wait may last; 0 disables the timeout.
- CNT_W, 16, width of num_inst.

**Ports**
- clk, in, 1: single clock; all state updates on posedge.
- reset, in, 1: asynchronous, active-high; forces the reset state immediately.
- readM, out, 1: memory read request.
- writeM, out, 1: memory write request.
- address, out, 16: memory address.
- data, inout, 16: driven with rf[rt] only while writeM=1, otherwise high-Z.
- inputReady, in, 1: read data valid and acknowledge.
- ackOutput, in, 1: write acknowledge.
- num_inst, out, CNT_W: retired-instruction count.
- output_port, out, 16: last value written by WWD.
- is_halted, out, 1: HLT executed.
- bus_error, out, 1: handshake timeout occurred.

## Operation

- Register file: 4 × 16 bits. PC is 16 bits. Reset values: rf = 0, PC = RESET_PC, all outputs 0, data = Z.
- FSM states:
  - F_REQ: readM=1, address=PC. Leaves on inputReady=1; IR is latched from data in that cycle.
  - F_REL: readM=0. Leaves on inputReady=0.
  - EXEC: executes the instruction, PC advances.
  - R_REQ / R_REL: same handshake as F_REQ / F_REL; rf[rt] is latched in R_REQ.
  - W_REQ: writeM=1. Leaves on ackOutput=1.
  - W_REL: writeM=0. Leaves on ackOutput=0.
  - HALT and FAULT: terminal until reset.
- Instruction fields:
  - op = IR[15:12], rs = IR[11:10], rt = IR[9:8], rd = IR[7:6], func = IR[5:0].
  - imm = IR[7:0], sign-extended for ADI, LWD, SWD and branches; zero-extended for ORI.
  - tgt = IR[11:0].
- Opcodes:
  - BNE 0, BEQ 1, BGZ 2 (>0 signed), BLZ 3 (<0 signed): taken target = PC+1+sext(imm).
  - ADI 4, ORI 5, LHI 6 (rt = {imm, 8'h00}).
  - LWD 7 and SWD 8: address = rs + sext(imm).
  - JMP 9 and JAL 10: target = {PC+1[15:12], tgt}. JAL writes r2 = PC+1.
- R-type (op 15), by func:
  - 0–7: ADD, SUB, AND, ORR, NOT, TCP, SHL, SHR. Results go to rd. SHR is arithmetic. Overflow wraps mod 2^16.
  - 25 JPR: PC = rs.
  - 26 JRL: r2 = PC+1, then PC = old rs. Old rs is used even when rs = 2.
  - 28 WWD: output_port = rs.
  - 29 HLT: go to HALT.
- Undefined opcodes (11–14) and undefined funcs act as NOP: PC+1, counted as retired.
- num_inst increments by 1 per retired instruction, including HLT. LWD and SWD retire on leaving R_REL or W_REL. The counter wraps at 2^CNT_W.
- Timeout:
  - A wait counter resets on every state change.
  - If any REQ or REL state persists for TIMEOUT cycles (TIMEOUT ≠ 0), go to FAULT.
  - FAULT: bus_error=1, readM=writeM=0, data=Z, and no further state change.
- HALT: is_halted=1, no bus activity, registers frozen.

## Timing

- Request outputs are registered (Moore). readM/writeM drop in the cycle after the acknowledge is sampled.
- With a one-cycle-responding memory, non-memory instructions take 4 cycles (F_REQ ×2, F_REL, EXEC). LWD and SWD add 3 cycles.
- A new request is never raised while the previous acknowledge is still high.
- If inputReady is already 1 on entry to F_REQ, the IR is captured in the first cycle. Remaining in REL still enforces the four-phase protocol.
- Asserting reset mid-handshake drops readM/writeM and releases data asynchronously. Partial writes are the memory's concern.

## Structure

- Shared package cpu_pkg holds:
  - opcode and func constants (same values as the existing opcode definitions);
  - the FSM state enum;
  - the instruction field-slice helpers.
- Natural sub-module: cpu_alu, which is combinational. Inputs: a, b, func. Output: result. Covers funcs 0–7.

## Test plan

- Reset: assert reset mid-F_REQ. All outputs return to 0 immediately, data=Z, and the next fetch is from address RESET_PC.
- ADI then WWD: r1 = 0x0005, ADI r1,r1,0xFE, WWD r1. Expect output_port = 0x0003 and num_inst = 2.
- Memory handshake: SWD r2 → [r0+4] with r2 = 0xBEEF, then LWD r3 ← [4]. Expect a write of 0xBEEF at address 4, r3 = 0xBEEF, and no overlap of readM and writeM.
- Backward branch loop: BNE at PC 0x0010 with imm 0xFD, taken 3 times. Expect the next PCs to be 0x000E each time, and exit on equality.
- JAL/JRL: JAL at PC 0x1003 with tgt 0x020. Expect PC = 0x1020 and r2 = 0x1004. JRL r2 with rs = 2 then jumps to 0x1004 and writes r2 = 0x1021.
- Timeout and halt:
  - Hold inputReady=0 with TIMEOUT=8. Expect bus_error=1 after 8 cycles in F_REQ and readM=0.
  - Separately, execute HLT. Expect is_halted=1, num_inst to include the HLT, and no further requests.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the multi-cycle 16-bit core: opcodes, funcs,
// FSM states and instruction field helpers.
package cpu_pkg;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  typedef enum logic [3:0] {
    F_REQ, F_REL, EXEC, R_REQ, R_REL, W_REQ, W_REL, HALT, FAULT
  } state_t;

  // imm = {rd, func}, tgt = {rs, rt, rd, func}
  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
    logic [5:0] func;
  } instr_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] zext8(input logic [7:0] v);
    return {8'h00, v};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the R-type arithmetic/logic funcs 0-7.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [5:0]  func,
  output logic [15:0] result
);

  always_comb begin
    result = '0;
    case (func)
      FN_ADD:  result = a + b;
      FN_SUB:  result = a - b;
      FN_AND:  result = a & b;
      FN_ORR:  result = a | b;
      FN_NOT:  result = ~a;
      FN_TCP:  result = ~a + 16'd1;
      FN_SHL:  result = {a[14:0], 1'b0};
      FN_SHR:  result = {a[15], a[15:1]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle 16-bit CPU core with a four-phase memory handshake, bus timeout,
// retired-instruction counter, WWD output port and HLT.
module cpu_mc
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             readM,
  output logic             writeM,
  output logic [15:0]      address,
  inout  logic [15:0]      data,
  input  logic             inputReady,
  input  logic             ackOutput,
  output logic [CNT_W-1:0] num_inst,
  output logic [15:0]      output_port,
  output logic             is_halted,
  output logic             bus_error
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             state_q;
  instr_t             ir_q;
  logic [15:0]        pc_q, address_q, output_port_q;
  logic [15:0]        rf_q [4];
  logic [CNT_W-1:0]   num_inst_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               readM_q, writeM_q, is_halted_q, bus_error_q;

  logic [7:0]  imm8;
  logic [15:0] rs_val, rt_val, simm, pc_inc, pc_next, ea, wb_val, alu_y;
  logic [1:0]  wb_idx;
  logic        wb_en, wait_st, advance, timed_out, is_wwd, is_hlt;

  cpu_alu u_alu (.a(rs_val), .b(rt_val), .func(ir_q.func), .result(alu_y));

  always_comb begin
    imm8    = {ir_q.rd, ir_q.func};
    rs_val  = rf_q[ir_q.rs];
    rt_val  = rf_q[ir_q.rt];
    simm    = sext8(imm8);
    pc_inc  = pc_q + 16'd1;
    ea      = rs_val + simm;
    pc_next = pc_inc;
    wb_en   = 1'b0;
    wb_idx  = ir_q.rt;
    wb_val  = alu_y;
    is_wwd  = (ir_q.op == OP_RTYPE) && (ir_q.func == FN_WWD);
    is_hlt  = (ir_q.op == OP_RTYPE) && (ir_q.func == FN_HLT);
    case (ir_q.op)
      OP_BNE: if (rs_val != rt_val) pc_next = pc_inc + simm;
      OP_BEQ: if (rs_val == rt_val) pc_next = pc_inc + simm;
      OP_BGZ: if (!rs_val[15] && (rs_val != '0)) pc_next = pc_inc + simm;
      OP_BLZ: if (rs_val[15]) pc_next = pc_inc + simm;
      OP_ADI: begin wb_en = 1'b1; wb_val = rs_val + simm; end
      OP_ORI: begin wb_en = 1'b1; wb_val = rs_val | zext8(imm8); end
      OP_LHI: begin wb_en = 1'b1; wb_val = {imm8, 8'h00}; end
      OP_JMP: pc_next = {pc_inc[15:12], ir_q.rs, ir_q.rt, imm8};
      OP_JAL: begin
        pc_next = {pc_inc[15:12], ir_q.rs, ir_q.rt, imm8};
        wb_en = 1'b1; wb_idx = 2'd2; wb_val = pc_inc;
      end
      OP_RTYPE: begin
        if (ir_q.func[5:3] == 3'd0) begin
          wb_en = 1'b1; wb_idx = ir_q.rd;
        end else if (ir_q.func == FN_JPR) begin
          pc_next = rs_val;
        end else if (ir_q.func == FN_JRL) begin
          // rs is read before the r2 write lands, so JRL r2 uses the old r2
          pc_next = rs_val;
          wb_en = 1'b1; wb_idx = 2'd2; wb_val = pc_inc;
        end
      end
      default: ;
    endcase

    wait_st = (state_q == F_REQ) || (state_q == F_REL) || (state_q == R_REQ) ||
              (state_q == R_REL) || (state_q == W_REQ) || (state_q == W_REL);
    case (state_q)
      F_REQ:   advance = readM_q && inputReady;
      R_REQ:   advance = inputReady;
      F_REL,
      R_REL:   advance = !inputReady;
      W_REQ:   advance = ackOutput;
      W_REL:   advance = !ackOutput;
      default: advance = 1'b0;
    endcase
    timed_out = (TIMEOUT != 0) && (wait_q == WAIT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= F_REQ;
      ir_q          <= '0;
      pc_q          <= RESET_PC;
      address_q     <= '0;
      output_port_q <= '0;
      num_inst_q    <= '0;
      wait_q        <= '0;
      readM_q       <= 1'b0;
      writeM_q      <= 1'b0;
      is_halted_q   <= 1'b0;
      bus_error_q   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      wait_q <= (advance || !wait_st) ? '0 : wait_q + WAIT_W'(1);
      if (wait_st && !advance && timed_out) begin
        state_q     <= FAULT;
        readM_q     <= 1'b0;
        writeM_q    <= 1'b0;
        bus_error_q <= 1'b1;
      end else begin
        unique case (state_q)
          F_REQ: begin
            // the request is (re)raised here so the first fetch after reset works too
            readM_q   <= 1'b1;
            address_q <= pc_q;
            if (advance) begin
              ir_q    <= instr_t'(data);
              readM_q <= 1'b0;
              state_q <= F_REL;
            end
          end
          F_REL: if (advance) state_q <= EXEC;
          EXEC: begin
            pc_q <= pc_next;
            if (wb_en) rf_q[wb_idx] <= wb_val;
            if (is_wwd) output_port_q <= rs_val;
            if (ir_q.op == OP_LWD) begin
              address_q <= ea;
              readM_q   <= 1'b1;
              state_q   <= R_REQ;
            end else if (ir_q.op == OP_SWD) begin
              address_q <= ea;
              writeM_q  <= 1'b1;
              state_q   <= W_REQ;
            end else if (is_hlt) begin
              is_halted_q <= 1'b1;
              num_inst_q  <= num_inst_q + CNT_W'(1);
              state_q     <= HALT;
            end else begin
              address_q  <= pc_next;
              readM_q    <= 1'b1;
              num_inst_q <= num_inst_q + CNT_W'(1);
              state_q    <= F_REQ;
            end
          end
          R_REQ: if (advance) begin
            rf_q[ir_q.rt] <= data;
            readM_q       <= 1'b0;
            state_q       <= R_REL;
          end
          W_REQ: if (advance) begin
            writeM_q <= 1'b0;
            state_q  <= W_REL;
          end
          R_REL, W_REL: if (advance) begin
            num_inst_q <= num_inst_q + CNT_W'(1);
            address_q  <= pc_q;
            readM_q    <= 1'b1;
            state_q    <= F_REQ;
          end
          HALT, FAULT: ;
          default: ;
        endcase
      end
    end
  end

  assign data        = writeM_q ? rf_q[ir_q.rt] : 'z;
  assign readM       = readM_q;
  assign writeM      = writeM_q;
  assign address     = address_q;
  assign num_inst    = num_inst_q;
  assign output_port = output_port_q;
  assign is_halted   = is_halted_q;
  assign bus_error   = bus_error_q;

endmodule
